seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial pattern detector, the next generation of the board-level sequence detector. It shifts a bit stream into a PAT_W-bit history register that also drives the LED bank, and compares the history against a run-time pattern under a don't-care mask. The bit stream comes either from an internal cyclic replay of a loaded stream word, stepped by a built-in prescaler, or from an external valid-qualified bit input. The block supports overlapping and non-overlapping detection and keeps a saturating match counter.

## Interface
- PAT_W, 8: pattern and history width, ≥2
- STREAM_W, 16: replay stream length in bits, ≥2, any value (not restricted to a power of 2)
- DIV_W, 26: prescaler width; internal step period is 2^DIV_W clk cycles
- CNT_W, 8: match counter width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- src_sel  in  1  0 = internal replay, 1 = external bit
- stream  in  STREAM_W  replay word; stream[0] is emitted first
- ext_bit  in  1  external serial bit
- ext_valid  in  1  single-cycle qualifier for ext_bit
- pattern  in  PAT_W  target; pattern[PAT_W-1] is the oldest bit
- care_mask  in  PAT_W  1 = compare this bit, 0 = don't care
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- clear_cnt  in  1  synchronous clear of match_cnt
- history  out  PAT_W  shift register and LED drive; newest bit is history[0]
- detect  out  1  level; high from a matching step until the next step
- detect_pulse  out  1  one-clk strobe per match
- match_cnt  out  CNT_W  saturating match count

## Operation
- Step source:
  - internal mode: step = prescaler tick. The prescaler is free-running and wraps; it ticks when it equals 2^DIV_W−1.
  - external mode: step = ext_valid.
  - The prescaler runs in both modes.
- Bit source:
  - internal: b = stream[idx]; idx advances on each internal step and wraps from STREAM_W−1 to 0 explicitly.
  - external: b = ext_bit. idx holds.
- Each step:
  - history ← {history[PAT_W-2:0], b}
  - fill ← min(fill+1, PAT_W)
- Match on a step: (new fill == PAT_W) and ((new_history ^ pattern) & care_mask) == 0. care_mask = 0 matches on every step once the history is full.
- On a match:
  - detect ← 1 and detect_pulse ← 1.
  - match_cnt increments, saturating at 2^CNT_W−1.
  - If overlap = 0, fill ← 0. history is kept for display, and the next match needs PAT_W fresh bits.
- On a non-matching step: detect ← 0.
- Between steps: detect holds its value; detect_pulse is 0.
- clear_cnt: match_cnt ← 0. clear_cnt asserted in the same cycle as a match wins, so match_cnt = 0.
- pattern, care_mask, overlap and src_sel are sampled on each step. A mode change affects the next step only; idx and history are retained.

## Timing
- Reset values: history 0, detect 0, detect_pulse 0, match_cnt 0, idx 0, fill 0, prescaler 0.
- Step in cycle t (tick or ext_valid high): history, detect, detect_pulse and match_cnt all show the result after the clk edge ending cycle t. Latency is 1 clk, with no extra lag between history and detect.
- The first internal step occurs 2^DIV_W clk cycles after rst_n deasserts.
- ext_valid held high is a step every cycle; no back-pressure exists.
- rst_n low mid-operation clears all state immediately; detection restarts with an empty history.

## Structure
- Package seq_det_pkg holds:
  - constants SRC_INT = 1'b0 and SRC_EXT = 1'b1
  - default parameter values
- Sub-module tick_divider (parameter DIV_W; ports clk, rst_n, tick) holds the prescaler.
- Top level holds idx, fill, history, compare and counter.

## Test plan
Unless stated otherwise: PAT_W=8, care_mask=8'hFF, DIV_W=2, src_sel=1.
- Reset values: pattern=8'hB9, overlap=1, feed external bits 1,0,1,1,1,0,0,1 → after the 8th step history=8'hB9, detect=1, detect_pulse=1 for one clk, match_cnt=1. With bits 1,0,1,1,1,0,0 only (7 steps) → detect=0.
- Overlap mode: pattern=8'hAA, feed 1,0,1,0,1,0,1,0,1,0 (10 bits). overlap=1 → matches at steps 8 and 10, match_cnt=2. overlap=0 → match at step 8 only, match_cnt=1.
- Don't-care mask: pattern=8'hA0, care_mask=8'hF0, feed 1,0,1,0,1,1,1,1 → match. Feed 1,1,1,0,0,0,0,0 → no match.
- Saturation and clear: CNT_W=2, care_mask=8'h00, 5 matching steps → match_cnt=3. Then clear_cnt asserted together with a match step → match_cnt=0.
- Internal replay and wrap: src_sel=0, STREAM_W=5, stream=5'b00001 → steps every 4 clk. After 5 steps history=8'h10; after the 6th step history=8'h21, confirming idx wrapped to 0.
- Reset mid-fill: pull rst_n low after 5 external bits → all outputs 0 immediately. Then the 8-bit B9 sequence → first detect exactly on its 8th step.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and default parameters for the sequence detector
package seq_det_pkg;
    localparam logic SRC_INT = 1'b0;
    localparam logic SRC_EXT = 1'b1;
    localparam int PAT_W_DEF = 8;
    localparam int STREAM_W_DEF = 16;
    localparam int DIV_W_DEF = 26;
    localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running wrapping prescaler, ticks when all ones
module tick_divider #(
    parameter int DIV_W = seq_det_pkg::DIV_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    logic [DIV_W-1:0] cnt;
    always_comb tick = &cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= cnt + 1'b1;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: masked serial pattern detector with replay or external bit source
module seq_detector_param #(
    parameter int PAT_W    = seq_det_pkg::PAT_W_DEF,
    parameter int STREAM_W = seq_det_pkg::STREAM_W_DEF,
    parameter int DIV_W    = seq_det_pkg::DIV_W_DEF,
    parameter int CNT_W    = seq_det_pkg::CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                src_sel,
    input  logic [STREAM_W-1:0] stream,
    input  logic                ext_bit,
    input  logic                ext_valid,
    input  logic [PAT_W-1:0]    pattern,
    input  logic [PAT_W-1:0]    care_mask,
    input  logic                overlap,
    input  logic                clear_cnt,
    output logic [PAT_W-1:0]    history,
    output logic                detect,
    output logic                detect_pulse,
    output logic [CNT_W-1:0]    match_cnt
);
    import seq_det_pkg::*;
    localparam int IW = $clog2(STREAM_W);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(STREAM_W - 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);
    logic tick, step, b, match;
    logic [IW-1:0] idx;
    logic [FW-1:0] fill, fill_nxt;
    logic [PAT_W-1:0] hist_nxt;
    tick_divider #(.DIV_W(DIV_W)) u_div (.clk(clk), .rst_n(rst_n), .tick(tick));
    always_comb begin
        step = (src_sel == SRC_EXT) ? ext_valid : tick;
        b = (src_sel == SRC_EXT) ? ext_bit : stream[idx];
        hist_nxt = {history[PAT_W-2:0], b};
        fill_nxt = (fill == FULL) ? FULL : fill + 1'b1;
        match = step && (fill_nxt == FULL) && (((hist_nxt ^ pattern) & care_mask) == '0);
    end
    // fill counts fresh bits; non-overlap mode empties it so the next match needs PAT_W new bits
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            history <= '0;
            detect <= 1'b0;
            detect_pulse <= 1'b0;
            match_cnt <= '0;
            idx <= '0;
            fill <= '0;
        end else begin
            detect_pulse <= match;
            if (step) begin
                history <= hist_nxt;
                fill <= (match && !overlap) ? '0 : fill_nxt;
                detect <= match;
            end
            if (step && src_sel == SRC_INT) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            match_cnt <= clear_cnt ? '0 : (match && !(&match_cnt)) ? match_cnt + 1'b1 : match_cnt;
        end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: table vectors, corner sequences and randomized model check
module tb_seq_detector_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic src_sel = 1'b1;
    logic [4:0] stream = 5'b00001;
    logic ext_bit = 1'b0;
    logic ext_valid = 1'b0;
    logic [7:0] pattern = 8'hB9;
    logic [7:0] care_mask = 8'hFF;
    logic overlap = 1'b1;
    logic clear_cnt = 1'b0;
    logic [7:0] history;
    logic detect, detect_pulse;
    logic [1:0] match_cnt;
    int total = 0;
    int bad = 0;

    seq_detector_param #(.PAT_W(8), .STREAM_W(5), .DIV_W(2), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .src_sel(src_sel), .stream(stream), .ext_bit(ext_bit),
        .ext_valid(ext_valid), .pattern(pattern), .care_mask(care_mask), .overlap(overlap),
        .clear_cnt(clear_cnt), .history(history), .detect(detect), .detect_pulse(detect_pulse),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pat;
        logic [7:0] mask;
        logic ovl;
        int n;
        logic [15:0] seq;
        logic [7:0] hist;
        logic det;
        int cnt;
        int pulses;
    } vec_t;
    vec_t tv[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ext_valid = 1'b0;
        clear_cnt = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic ext_step(input logic bv, input logic clr);
        ext_bit = bv;
        ext_valid = 1'b1;
        clear_cnt = clr;
        @(negedge clk);
        ext_valid = 1'b0;
        clear_cnt = 1'b0;
    endtask

    logic [7:0] b9 = 8'hB9;
    logic [7:0] mh;
    logic md, mp, m, st, bb, sel, vld, eb, clr;
    int mfresh, mc, cyc, k, pulses;

    initial begin
        tv[0] = '{8'hB9, 8'hFF, 1'b1, 8, 16'h00B9, 8'hB9, 1'b1, 1, 1};
        tv[1] = '{8'hB9, 8'hFF, 1'b1, 7, 16'h005C, 8'h5C, 1'b0, 0, 0};
        tv[2] = '{8'hAA, 8'hFF, 1'b1, 10, 16'h02AA, 8'hAA, 1'b1, 2, 2};
        tv[3] = '{8'hAA, 8'hFF, 1'b0, 10, 16'h02AA, 8'hAA, 1'b0, 1, 1};
        tv[4] = '{8'hA0, 8'hF0, 1'b1, 8, 16'h00AF, 8'hAF, 1'b1, 1, 1};
        tv[5] = '{8'hA0, 8'hF0, 1'b1, 8, 16'h00E0, 8'hE0, 1'b0, 0, 0};
        tv[6] = '{8'h00, 8'h00, 1'b1, 12, 16'h0000, 8'h00, 1'b1, 3, 5};

        do_reset();
        chk("reset_outputs", {history, detect, detect_pulse, match_cnt}, 32'h0);

        for (int v = 0; v < 7; v++) begin
            src_sel = 1'b1;
            pattern = tv[v].pat;
            care_mask = tv[v].mask;
            overlap = tv[v].ovl;
            do_reset();
            pulses = 0;
            for (int i = tv[v].n - 1; i >= 0; i--) begin
                ext_step(tv[v].seq[i], 1'b0);
                pulses += int'(detect_pulse);
            end
            chk($sformatf("vec%0d_history", v), history, tv[v].hist);
            chk($sformatf("vec%0d_detect", v), detect, tv[v].det);
            chk($sformatf("vec%0d_count", v), match_cnt, tv[v].cnt);
            chk($sformatf("vec%0d_pulses", v), pulses, tv[v].pulses);
        end

        pattern = 8'hB9; care_mask = 8'hFF; overlap = 1'b1;
        do_reset();
        for (int i = 7; i >= 0; i--) ext_step(b9[i], 1'b0);
        chk("b9_pulse_on_step", detect_pulse, 1'b1);
        @(negedge clk);
        chk("b9_pulse_one_clk", detect_pulse, 1'b0);
        chk("b9_detect_holds", detect, 1'b1);
        ext_step(1'b0, 1'b0);
        chk("b9_detect_drops", detect, 1'b0);

        pattern = 8'h00; care_mask = 8'h00;
        do_reset();
        for (int i = 0; i < 12; i++) ext_step(1'b1, 1'b0);
        chk("sat_count", match_cnt, 2'd3);
        ext_step(1'b1, 1'b1);
        chk("clear_wins_count", match_cnt, 2'd0);
        chk("clear_wins_pulse", detect_pulse, 1'b1);
        ext_step(1'b1, 1'b0);
        chk("count_after_clear", match_cnt, 2'd1);

        pattern = 8'hB9; care_mask = 8'hFF;
        src_sel = 1'b0;
        stream = 5'b00001;
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            @(negedge clk);
            if (e == 3) chk("int_no_early_step", history, 8'h00);
            if (e == 4) chk("int_first_step", history, 8'h01);
            if (e == 19) chk("int_four_steps", history, 8'h08);
            if (e == 20) chk("int_five_steps", history, 8'h10);
            if (e == 24) chk("int_wrap", history, 8'h21);
        end

        src_sel = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) ext_step(1'b1, 1'b0);
        chk("pre_reset_history", history, 8'h1F);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {history, detect, detect_pulse, match_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            ext_step(b9[i], 1'b0);
            chk($sformatf("restart_step%0d", 8 - i), detect, i == 0);
        end

        stream = 5'($urandom);
        pattern = 8'($urandom);
        care_mask = 8'($urandom & $urandom & $urandom);
        do_reset();
        mh = 0; md = 0; mp = 0; mfresh = 0; mc = 0; cyc = 0; k = 0;
        sel = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 63) begin
                pattern = 8'($urandom);
                care_mask = 8'($urandom & $urandom & $urandom);
            end
            if ($urandom_range(0, 15) == 0) sel = ~sel;
            vld = 1'($urandom);
            eb = 1'($urandom);
            clr = ($urandom_range(0, 31) == 0);
            overlap = 1'($urandom);
            src_sel = sel; ext_valid = vld; ext_bit = eb; clear_cnt = clr;
            st = sel ? vld : (cyc % 4 == 3);
            bb = sel ? eb : stream[k % 5];
            mp = 1'b0;
            if (st) begin
                if (!sel) k++;
                mh = {mh[6:0], bb};
                mfresh = (mfresh < 8) ? mfresh + 1 : 8;
                m = (mfresh == 8) && (((mh ^ pattern) & care_mask) == 8'h00);
                md = m;
                mp = m;
                if (m && !overlap) mfresh = 0;
            end
            mc = clr ? 0 : (mp && mc < 3) ? mc + 1 : mc;
            cyc++;
            @(negedge clk);
            chk("random", {history, detect, detect_pulse, match_cnt}, {mh, md, mp, mc[1:0]});
        end
        ext_valid = 1'b0;
        clear_cnt = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
